// File: rtl/byte_mem_pkg.sv
// rtl/byte_mem_pkg.sv - shared command/state encodings for the byte-serial memory responder
package byte_mem_pkg;

    localparam int BEATS_PER_WORD = 4;

    typedef enum logic [1:0] {
        CMD_FETCH = 2'b00,
        CMD_STORE = 2'b01,
        CMD_LOAD  = 2'b10,
        CMD_JUMP  = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_SEND_INST = 2'b01,
        ST_COLLECT   = 2'b10,
        ST_SEND_DATA = 2'b11
    } state_e;

    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] k);
        return w[{k, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/word_ram.sv
// rtl/word_ram.sv - word storage, one arbitrated write port and one combinational read port
module word_ram #(
    parameter int WORDS = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          init_we,
    input  logic [AW-1:0] init_addr,
    input  logic [31:0]   init_data,
    input  logic          store_we,
    input  logic [AW-1:0] store_addr,
    input  logic [31:0]   store_data,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0]   mem [WORDS];
    logic          we;
    logic [AW-1:0] waddr;
    logic [31:0]   wdata;

    // STORE commits only outside IDLE and init only inside it, so priority is a formality
    always_comb begin
        we    = 1'b0;
        waddr = init_addr;
        wdata = init_data;
        if (store_we) begin
            we    = 1'b1;
            waddr = store_addr;
            wdata = store_data;
        end else if (init_we) begin
            we    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/byte_mem_responder.sv
// rtl/byte_mem_responder.sv - byte-serial FETCH/STORE/LOAD/JUMP responder over a word memory
// Optional RESP_ERR_FLAG_EN adds the sticky out-of-range err output.
module byte_mem_responder
    import byte_mem_pkg::*;
#(
    parameter int MEM_WORDS = 64,
    parameter int RESET_PC  = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_valid,
    input  logic [1:0]                   cmd,
    input  logic                         byte_valid,
    input  logic [7:0]                   addr_byte,
    input  logic [7:0]                   data_byte,
    input  logic                         init_we,
    input  logic [$clog2(MEM_WORDS)-1:0] init_addr,
    input  logic [31:0]                  init_data,
    output logic [7:0]                   rd_byte,
    output logic                         rd_valid,
    output logic                         busy
`ifdef RESP_ERR_FLAG_EN
    ,
    output logic                         err
`endif
);

    localparam int AW = $clog2(MEM_WORDS);

    state_e        state_q, state_d;
    cmd_e          cmd_q;
    logic [1:0]    beat_q;
    logic [AW-1:0] pc_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   ldata_q;
    logic [31:0]   mem_rdata;
    logic [31:0]   full_addr;
    logic [31:0]   full_wdata;
    logic [AW-1:0] full_idx;
    logic [AW-1:0] ram_raddr;
    logic          beat_last;
    logic          commit;
    logic          oor;
    logic          store_we;
    logic          unused_addr_bits;

    assign beat_last = (beat_q == 2'(BEATS_PER_WORD - 1));
    // The last beat's byte is still on the bus at the commit edge, so splice it in directly
    assign full_addr  = {addr_byte, addr_q[23:0]};
    assign full_wdata = {data_byte, wdata_q[23:0]};
    assign full_idx   = full_addr[AW+1:2];
    assign commit     = (state_q == ST_COLLECT) && byte_valid && beat_last;
    assign busy       = (state_q != ST_IDLE);

`ifdef RESP_ERR_FLAG_EN
    assign oor = |full_addr[31:AW+2];
    assign unused_addr_bits = ^{full_addr[1:0], addr_q[31:24], wdata_q[31:24]};
`else
    assign oor = 1'b0;
    assign unused_addr_bits = ^{full_addr[31:AW+2], full_addr[1:0], addr_q[31:24], wdata_q[31:24]};
`endif

    assign store_we  = commit && (cmd_q == CMD_STORE) && !oor;
    assign ram_raddr = (state_q == ST_COLLECT) ? full_idx : pc_q;

    word_ram #(
        .WORDS (MEM_WORDS),
        .AW    (AW)
    ) u_word_ram (
        .clk        (clk),
        .init_we    (init_we && (state_q == ST_IDLE)),
        .init_addr  (init_addr),
        .init_data  (init_data),
        .store_we   (store_we),
        .store_addr (full_idx),
        .store_data (full_wdata),
        .raddr      (ram_raddr),
        .rdata      (mem_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d = (cmd_e'(cmd) == CMD_FETCH) ? ST_SEND_INST : ST_COLLECT;
                end
            end
            ST_SEND_INST, ST_SEND_DATA: begin
                if (byte_valid && beat_last) begin
                    state_d = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (byte_valid && beat_last) begin
                    state_d = (cmd_q == CMD_LOAD) ? ST_SEND_DATA : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_q    <= CMD_FETCH;
            beat_q   <= 2'd0;
            pc_q     <= AW'(RESET_PC);
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            ldata_q  <= 32'd0;
            rd_byte  <= 8'd0;
            rd_valid <= 1'b0;
`ifdef RESP_ERR_FLAG_EN
            err      <= 1'b0;
`endif
        end else begin
            rd_valid <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        cmd_q  <= cmd_e'(cmd);
                        beat_q <= 2'd0;
                    end
                end
                ST_SEND_INST: begin
                    if (byte_valid) begin
                        rd_byte  <= word_byte(mem_rdata, beat_q);
                        rd_valid <= 1'b1;
                        beat_q   <= beat_q + 2'd1;
                        if (beat_last) begin
                            pc_q <= pc_q + AW'(1);
                        end
                    end
                end
                ST_COLLECT: begin
                    if (byte_valid) begin
                        addr_q[{beat_q, 3'b000} +: 8]  <= addr_byte;
                        wdata_q[{beat_q, 3'b000} +: 8] <= data_byte;
                        beat_q <= beat_q + 2'd1;
                        if (beat_last) begin
                            if (cmd_q == CMD_JUMP && !oor) begin
                                pc_q <= full_idx;
                            end
                            if (cmd_q == CMD_LOAD) begin
                                ldata_q <= oor ? 32'd0 : mem_rdata;
                            end
`ifdef RESP_ERR_FLAG_EN
                            if (oor) begin
                                err <= 1'b1;
                            end
`endif
                        end
                    end
                end
                ST_SEND_DATA: begin
                    if (byte_valid) begin
                        rd_byte  <= word_byte(ldata_q, beat_q);
                        rd_valid <= 1'b1;
                        beat_q   <= beat_q + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_byte_mem_responder.sv
// tb/tb_byte_mem_responder.sv - directed self-checking bench for byte_mem_responder
module tb_byte_mem_responder;

    localparam logic [1:0] FETCH = 2'b00;
    localparam logic [1:0] STORE = 2'b01;
    localparam logic [1:0] LOAD  = 2'b10;
    localparam logic [1:0] JUMP  = 2'b11;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic [1:0] cmd;
    logic       byte_valid;
    logic [7:0] addr_byte;
    logic [7:0] data_byte;
    logic       init_we;
    logic [5:0] init_addr;
    logic [31:0] init_data;
    logic [7:0] rd_byte;
    logic       rd_valid;
    logic       busy;
`ifdef RESP_ERR_FLAG_EN
    logic       err;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    byte_mem_responder #(.MEM_WORDS(64), .RESET_PC(0)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd        (cmd),
        .byte_valid (byte_valid),
        .addr_byte  (addr_byte),
        .data_byte  (data_byte),
        .init_we    (init_we),
        .init_addr  (init_addr),
        .init_data  (init_data),
        .rd_byte    (rd_byte),
        .rd_valid   (rd_valid),
        .busy       (busy)
`ifdef RESP_ERR_FLAG_EN
        ,
        .err        (err)
`endif
    );

    task automatic preload(input logic [5:0] a, input logic [31:0] d);
        @(negedge clk);
        init_we = 1'b1; init_addr = a; init_data = d;
        @(negedge clk);
        init_we = 1'b0;
    endtask

    task automatic start_cmd(input logic [1:0] c);
        @(negedge clk);
        cmd_valid = 1'b1; cmd = c;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic collect(input logic [31:0] a, input logic [31:0] d, input int nbeats);
        for (int k = 0; k < nbeats; k++) begin
            addr_byte = a[8*k +: 8];
            data_byte = d[8*k +: 8];
            byte_valid = 1'b1;
            @(negedge clk);
        end
        byte_valid = 1'b0;
    endtask

    task automatic read_word(input string name, input logic [31:0] w, input int gaps);
        for (int k = 0; k < 4; k++) begin
            byte_valid = 1'b1;
            @(negedge clk);
            byte_valid = 1'b0;
            n_cmp++;
            if (rd_valid !== 1'b1 || rd_byte !== w[8*k +: 8]) begin
                n_bad++;
                $display("FAIL %s beat %0d: got valid=%b byte=%02h, want valid=1 byte=%02h",
                         name, k, rd_valid, rd_byte, w[8*k +: 8]);
            end
            n_cmp++;
            if (busy !== (k != 3)) begin
                n_bad++;
                $display("FAIL %s busy beat %0d: got %b want %b", name, k, busy, (k != 3));
            end
            for (int g = 0; g < gaps; g++) begin
                @(negedge clk);
                n_cmp++;
                if (rd_valid !== 1'b0) begin
                    n_bad++;
                    $display("FAIL %s gap rd_valid beat %0d: got %b want 0", name, k, rd_valid);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; cmd_valid = 1'b0; cmd = 2'b00; byte_valid = 1'b0;
        addr_byte = 8'h00; data_byte = 8'h00; init_we = 1'b0; init_addr = 6'd0; init_data = 32'd0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (rd_valid !== 1'b0 || rd_byte !== 8'h00 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset: got valid=%b byte=%02h busy=%b want 0/00/0", rd_valid, rd_byte, busy);
        end
`ifdef RESP_ERR_FLAG_EN
        n_cmp++;
        if (err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset err: got %b want 0", err);
        end
`endif
        rst = 1'b1;
    endtask

    task automatic test_fetch();
        start_cmd(FETCH);
        read_word("fetch0", 32'h12345678, 0);
        start_cmd(FETCH);
        read_word("fetch_pc1", 32'hA1B2C3D4, 0);
    endtask

    task automatic test_store_load();
        start_cmd(STORE);
        collect(32'h0000_0008, 32'hDEADBEEF, 4);
        start_cmd(LOAD);
        collect(32'h0000_0008, 32'h0, 4);
        read_word("load_after_store", 32'hDEADBEEF, 0);
        start_cmd(LOAD);
        collect(32'h0000_000B, 32'h0, 4);
        read_word("load_low_bits_ignored", 32'hDEADBEEF, 0);
    endtask

    task automatic test_jump();
        start_cmd(JUMP);
        collect(32'h0000_000C, 32'h0, 4);
        start_cmd(FETCH);
        read_word("jump_fetch3", 32'hCAFEF00D, 0);
        start_cmd(FETCH);
        read_word("jump_fetch_pc4", 32'h0BADBEEF, 0);
        start_cmd(JUMP);
        collect(32'h0000_00FC, 32'h0, 4);
        start_cmd(FETCH);
        read_word("fetch63", 32'h0F0E0D0C, 0);
        start_cmd(FETCH);
        read_word("pc_wrap_fetch0", 32'h12345678, 0);
    endtask

    task automatic test_gaps();
        start_cmd(JUMP);
        collect(32'h0000_0000, 32'h0, 4);
        start_cmd(FETCH);
        cmd_valid = 1'b1; cmd = JUMP;
        repeat (3) @(negedge clk);
        cmd_valid = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || rd_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL cmd_ignored_busy: got busy=%b valid=%b want 1/0", busy, rd_valid);
        end
        read_word("fetch_gaps", 32'h12345678, 2);
    endtask

    task automatic test_init_busy();
        start_cmd(LOAD);
        init_we = 1'b1; init_addr = 6'd5; init_data = 32'hFFFFFFFF;
        @(negedge clk);
        init_we = 1'b0;
        collect(32'h0000_0014, 32'h0, 4);
        read_word("init_while_busy", 32'h55667788, 0);
    endtask

    task automatic test_reset_mid();
        start_cmd(STORE);
        collect(32'h0000_0014, 32'h99999999, 2);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || rd_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid: got busy=%b valid=%b want 0/0", busy, rd_valid);
        end
        rst = 1'b1;
        start_cmd(LOAD);
        collect(32'h0000_0014, 32'h0, 4);
        read_word("reset_mid_no_write", 32'h55667788, 0);
        start_cmd(FETCH);
        read_word("reset_mid_pc", 32'h12345678, 0);
    endtask

`ifdef RESP_ERR_FLAG_EN
    task automatic test_err();
        start_cmd(STORE);
        collect(32'h0000_1000, 32'h55555555, 4);
        n_cmp++;
        if (err !== 1'b1) begin
            n_bad++;
            $display("FAIL err_set: got %b want 1", err);
        end
        start_cmd(LOAD);
        collect(32'h0000_0000, 32'h0, 4);
        read_word("err_mem_unchanged", 32'h12345678, 0);
        start_cmd(LOAD);
        collect(32'h0000_1000, 32'h0, 4);
        read_word("err_load_zero", 32'h00000000, 0);
        start_cmd(JUMP);
        collect(32'h0000_1000, 32'h0, 4);
        start_cmd(FETCH);
        read_word("err_jump_pc_kept", 32'hA1B2C3D4, 0);
        n_cmp++;
        if (err !== 1'b1) begin
            n_bad++;
            $display("FAIL err_sticky: got %b want 1", err);
        end
    endtask
`else
    task automatic test_wrap();
        start_cmd(LOAD);
        collect(32'h0000_1008, 32'h0, 4);
        read_word("wrap_load", 32'hDEADBEEF, 0);
        start_cmd(STORE);
        collect(32'h0000_1018, 32'h01020304, 4);
        start_cmd(LOAD);
        collect(32'h0000_0018, 32'h0, 4);
        read_word("wrap_store", 32'h01020304, 0);
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time=%0t want end before 500000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        preload(6'd0,  32'h12345678);
        preload(6'd1,  32'hA1B2C3D4);
        preload(6'd2,  32'h11223344);
        preload(6'd3,  32'hCAFEF00D);
        preload(6'd4,  32'h0BADBEEF);
        preload(6'd5,  32'h55667788);
        preload(6'd63, 32'h0F0E0D0C);
        test_fetch();
        test_store_load();
        test_jump();
        test_gaps();
        test_init_busy();
        test_reset_mid();
`ifdef RESP_ERR_FLAG_EN
        test_err();
`else
        test_wrap();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
